// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared opcodes, funct3 codes and the decode bundle type
package rv_pkg;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef struct packed {
      logic [XLEN-1:0]   x;
      logic [XLEN-1:0]   y;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic              imm;
      logic [REG_AW-1:0] rd;
      logic              wen;
      logic              mem_rd;
      logic              mem_wr;
      logic [2:0]        mem_funct3;
      logic [XLEN-1:0]   store_data;
      logic              illegal;
   } dec_bundle_t;
endpackage

// File: rtl/rv_scoreboard.sv
// rtl/rv_scoreboard.sv - per-register busy bits for read-after-write stalls
// Set wins over clear on the same register; x0 is never busy.
module rv_scoreboard
   import rv_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_addr,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_addr,
   input  logic [REG_AW-1:0] q1_addr,
   input  logic [REG_AW-1:0] q2_addr,
   output logic              q1_busy,
   output logic              q2_busy
);
   localparam int NREG = 1 << REG_AW;

   logic [NREG-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign q1_busy = busy_q[q1_addr];
   assign q2_busy = busy_q[q2_addr];
endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered decode stage with RAW scoreboard stall
// DEC_WB_BYPASS_EN: a writeback in the same cycle releases the stall (write-through RF).
module rv_decode_stage
   import rv_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_instr,
   input  logic [XLEN-1:0]   in_pc,
   output logic [REG_AW-1:0] rf_raddr1,
   output logic [REG_AW-1:0] rf_raddr2,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_x,
   output logic [XLEN-1:0]   out_y,
   output logic [2:0]        out_funct3,
   output logic [6:0]        out_funct7,
   output logic              out_imm,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_wen,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   output logic [2:0]        out_mem_funct3,
   output logic [XLEN-1:0]   out_store_data,
   output logic              out_illegal
);
   logic [6:0]        opcode;
   logic [REG_AW-1:0] rs1, rs2, rd;
   logic [2:0]        f3;
   logic [XLEN-1:0]   imm_i, imm_s, imm_u;
   logic              rs1_used, rs2_used, writes_rd;
   dec_bundle_t       dec;
   dec_bundle_t       bundle_q, bundle_d;
   logic              valid_q, valid_d;
   logic              busy1, busy2;
   logic              held1, held2, wb1, wb2, haz1, haz2, hazard, accept;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign f3     = in_instr[14:12];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_u  = {in_instr[31:12], 12'b0};

   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;

   always_comb begin
      dec       = '0;
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      writes_rd = 1'b0;
      case (opcode)
         OPC_OP: begin
            rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1;
            dec.x = rf_rdata1; dec.y = rf_rdata2;
            dec.funct3 = f3; dec.funct7 = in_instr[31:25];
            dec.imm = (f3 == F3_SR) ? in_instr[30] : 1'b0;
         end
         OPC_OP_IMM: begin
            rs1_used = 1'b1; writes_rd = 1'b1;
            dec.x = rf_rdata1; dec.funct3 = f3;
            // Shift immediates carry only the shamt; funct7 selects SRL/SRA
            if (f3 == F3_SLL || f3 == F3_SR) begin
               dec.y      = {27'b0, in_instr[24:20]};
               dec.funct7 = in_instr[31:25];
            end else begin
               dec.y      = imm_i;
            end
            dec.imm = (f3 == F3_SR) ? in_instr[30] : 1'b1;
         end
         OPC_LUI: begin
            writes_rd = 1'b1;
            dec.y = imm_u; dec.funct3 = F3_ADD; dec.imm = 1'b1;
         end
         OPC_AUIPC: begin
            writes_rd = 1'b1;
            dec.x = in_pc; dec.y = imm_u; dec.funct3 = F3_ADD; dec.imm = 1'b1;
         end
         OPC_LOAD: begin
            rs1_used = 1'b1; writes_rd = 1'b1;
            dec.x = rf_rdata1; dec.y = imm_i; dec.funct3 = F3_ADD; dec.imm = 1'b1;
            dec.mem_rd = 1'b1; dec.mem_funct3 = f3;
         end
         OPC_STORE: begin
            rs1_used = 1'b1; rs2_used = 1'b1;
            dec.x = rf_rdata1; dec.y = imm_s; dec.funct3 = F3_ADD; dec.imm = 1'b1;
            dec.mem_wr = 1'b1; dec.mem_funct3 = f3; dec.store_data = rf_rdata2;
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.rd  = rd;
      dec.wen = writes_rd && (rd != '0);
   end

   rv_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (valid_q && out_ready && bundle_q.wen),
      .set_addr (bundle_q.rd),
      .clr_en   (wb_valid),
      .clr_addr (wb_rd),
      .q1_addr  (rs1),
      .q2_addr  (rs2),
      .q1_busy  (busy1),
      .q2_busy  (busy2)
   );

   assign held1 = valid_q && bundle_q.wen && (bundle_q.rd == rs1);
   assign held2 = valid_q && bundle_q.wen && (bundle_q.rd == rs2);
`ifdef DEC_WB_BYPASS_EN
   assign wb1 = wb_valid && (wb_rd == rs1) && !held1;
   assign wb2 = wb_valid && (wb_rd == rs2) && !held2;
`else
   assign wb1 = 1'b0;
   assign wb2 = 1'b0;
`endif
   assign haz1   = rs1_used && (rs1 != '0) && ((busy1 && !wb1) || held1);
   assign haz2   = rs2_used && (rs2 != '0) && ((busy2 && !wb2) || held2);
   assign hazard = haz1 || haz2;

   assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      bundle_d = accept ? dec : bundle_q;
      if (flush)          valid_d = 1'b0;
      else if (accept)    valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
      else                valid_d = valid_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
      end else begin
         valid_q  <= valid_d;
         bundle_q <= bundle_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_x          = bundle_q.x;
   assign out_y          = bundle_q.y;
   assign out_funct3     = bundle_q.funct3;
   assign out_funct7     = bundle_q.funct7;
   assign out_imm        = bundle_q.imm;
   assign out_rd         = bundle_q.rd;
   assign out_wen        = bundle_q.wen;
   assign out_mem_rd     = bundle_q.mem_rd;
   assign out_mem_wr     = bundle_q.mem_wr;
   assign out_mem_funct3 = bundle_q.mem_funct3;
   assign out_store_data = bundle_q.store_data;
   assign out_illegal    = bundle_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - directed self-checking bench for rv_decode_stage
module tb_rv_decode_stage;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, wb_valid, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, rf_rdata1, rf_rdata2;
   logic [4:0]  rf_raddr1, rf_raddr2, wb_rd, out_rd;
   logic [31:0] out_x, out_y, out_store_data;
   logic [2:0]  out_funct3, out_mem_funct3;
   logic [6:0]  out_funct7;
   logic        out_imm, out_wen, out_mem_rd, out_mem_wr, out_illegal;
   int checks = 0;
   int failures = 0;

   rv_decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
      .out_y(out_y), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
      .out_rd(out_rd), .out_wen(out_wen), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_mem_funct3(out_mem_funct3), .out_store_data(out_store_data), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      in_instr = ins; rf_rdata1 = r1; rf_rdata2 = r2; in_valid = 1'b1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0; out_ready = 1'b1;
      in_instr = '0; in_pc = '0; rf_rdata1 = '0; rf_rdata2 = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_x !== 32'h0) begin failures++; $display("FAIL reset_x got=%h exp=0", out_x); end
      checks++; if (out_rd !== 5'd0 || out_wen !== 1'b0 || out_illegal !== 1'b0) begin failures++; $display("FAIL reset_ctl got rd=%0d wen=%b ill=%b exp 0", out_rd, out_wen, out_illegal); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_addi();
      do_reset();
      drive(32'hFFB00093, 32'h0, 32'h0); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL addi_ready got=%b exp=1", in_ready); end
      tick(); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
      checks++; if (out_x !== 32'h0) begin failures++; $display("FAIL addi_x got=%h exp=0", out_x); end
      checks++; if (out_y !== 32'hFFFFFFFB) begin failures++; $display("FAIL addi_y got=%h exp=fffffffb", out_y); end
      checks++; if (out_funct3 !== 3'b000 || out_imm !== 1'b1) begin failures++; $display("FAIL addi_f3imm got=%b/%b exp=000/1", out_funct3, out_imm); end
      checks++; if (out_rd !== 5'd1 || out_wen !== 1'b1) begin failures++; $display("FAIL addi_rd got=%0d/%b exp=1/1", out_rd, out_wen); end
   endtask

   task automatic test_sub();
      do_reset();
      drive(32'h402081B3, 32'd10, 32'd3); #1;
      checks++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin failures++; $display("FAIL sub_raddr got=%0d/%0d exp=1/2", rf_raddr1, rf_raddr2); end
      tick(); in_valid = 1'b0;
      checks++; if (out_funct3 !== 3'b000 || out_funct7 !== 7'b0100000) begin failures++; $display("FAIL sub_funct got=%b/%b exp=000/0100000", out_funct3, out_funct7); end
      checks++; if (out_imm !== 1'b0) begin failures++; $display("FAIL sub_imm got=%b exp=0", out_imm); end
      checks++; if (out_x !== 32'd10 || out_y !== 32'd3) begin failures++; $display("FAIL sub_xy got=%0d/%0d exp=10/3", out_x, out_y); end
      checks++; if (out_rd !== 5'd3 || out_illegal !== 1'b0) begin failures++; $display("FAIL sub_rd got=%0d/%b exp=3/0", out_rd, out_illegal); end
   endtask

   task automatic test_shifts();
      do_reset();
      drive(32'h4032D213, 32'h80000000, 32'h0);
      tick();
      checks++; if (out_y !== 32'd3 || out_funct3 !== 3'b101) begin failures++; $display("FAIL srai_y_f3 got=%h/%b exp=3/101", out_y, out_funct3); end
      checks++; if (out_funct7 !== 7'b0100000 || out_imm !== 1'b1) begin failures++; $display("FAIL srai_f7imm got=%b/%b exp=0100000/1", out_funct7, out_imm); end
      drive(32'h0062D233, 32'h80000000, 32'd4);
      tick(); in_valid = 1'b0;
      checks++; if (out_imm !== 1'b0 || out_funct7 !== 7'b0) begin failures++; $display("FAIL srl_imm got=%b/%b exp=0/0", out_imm, out_funct7); end
      checks++; if (out_y !== 32'd4 || out_funct3 !== 3'b101) begin failures++; $display("FAIL srl_y got=%h/%b exp=4/101", out_y, out_funct3); end
   endtask

   task automatic test_lui_auipc_mem();
      do_reset();
      drive(32'h12345437, 32'h0, 32'h0);
      tick();
      checks++; if (out_x !== 32'h0 || out_y !== 32'h12345000 || out_imm !== 1'b1 || out_rd !== 5'd8) begin failures++; $display("FAIL lui got x=%h y=%h imm=%b rd=%0d exp 0/12345000/1/8", out_x, out_y, out_imm, out_rd); end
      in_pc = 32'h100;
      drive(32'h00001497, 32'h0, 32'h0);
      tick();
      checks++; if (out_x !== 32'h100 || out_y !== 32'h1000 || out_funct3 !== 3'b000) begin failures++; $display("FAIL auipc got x=%h y=%h f3=%b exp 100/1000/000", out_x, out_y, out_funct3); end
      drive(32'hFFC12503, 32'h1000, 32'h0);
      tick();
      checks++; if (out_y !== 32'hFFFFFFFC || out_mem_rd !== 1'b1 || out_mem_funct3 !== 3'b010 || out_funct3 !== 3'b000 || out_x !== 32'h1000) begin failures++; $display("FAIL load got x=%h y=%h mrd=%b mf3=%b f3=%b", out_x, out_y, out_mem_rd, out_mem_funct3, out_funct3); end
      drive(32'h00B62423, 32'h2000, 32'hCAFEBABE);
      tick(); in_valid = 1'b0;
      checks++; if (out_y !== 32'd8 || out_mem_wr !== 1'b1 || out_wen !== 1'b0 || out_store_data !== 32'hCAFEBABE || out_x !== 32'h2000) begin failures++; $display("FAIL store got x=%h y=%h mwr=%b wen=%b sd=%h", out_x, out_y, out_mem_wr, out_wen, out_store_data); end
   endtask

   task automatic test_hazard();
      do_reset();
      drive(32'hFFB00093, 32'h0, 32'h0);
      tick();
      drive(32'h00108133, 32'd7, 32'd7); #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_held got=%b exp=0", in_ready); end
      tick();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL haz_busy got ready=%b valid=%b exp 0/0", in_ready, out_valid); end
      tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_busy2 got=%b exp=0", in_ready); end
      wb_valid = 1'b1; wb_rd = 5'd1; #1;
`ifdef DEC_WB_BYPASS_EN
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_wb_cycle got=%b exp=1", in_ready); end
      tick(); wb_valid = 1'b0;
`else
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL haz_wb_cycle got=%b exp=0", in_ready); end
      tick(); wb_valid = 1'b0; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL haz_after_wb got=%b exp=1", in_ready); end
      tick();
`endif
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_x !== 32'd7 || out_y !== 32'd7) begin failures++; $display("FAIL haz_issue got v=%b rd=%0d x=%0d y=%0d exp 1/2/7/7", out_valid, out_rd, out_x, out_y); end
   endtask

   task automatic test_backpressure_flush();
      do_reset();
      out_ready = 1'b0;
      drive(32'h00100293, 32'h0, 32'h0); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
      tick();
      drive(32'h00200313, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_y !== 32'd1 || out_rd !== 5'd5) begin failures++; $display("FAIL bp_hold cyc=%0d got v=%b y=%h rd=%0d exp 1/1/5", i, out_valid, out_y, out_rd); end
         tick();
      end
      flush = 1'b1; #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
      tick(); flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
      out_ready = 1'b1;
      drive(32'h00028393, 32'h0, 32'h0); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_busy_x5 got=%b exp=1", in_ready); end
      tick(); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin failures++; $display("FAIL flush_next got v=%b rd=%0d exp 1/7", out_valid, out_rd); end
   endtask

   task automatic test_illegal();
      do_reset();
      drive(32'h00208063, 32'd5, 32'd6);
      tick(); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_wen !== 1'b0) begin failures++; $display("FAIL illegal got v=%b ill=%b wen=%b exp 1/1/0", out_valid, out_illegal, out_wen); end
      checks++; if (out_x !== 32'h0 || out_y !== 32'h0 || out_mem_rd !== 1'b0 || out_mem_wr !== 1'b0) begin failures++; $display("FAIL illegal_ops got x=%h y=%h mrd=%b mwr=%b exp 0", out_x, out_y, out_mem_rd, out_mem_wr); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(32'hFFB00093, 32'h0, 32'h0);
      tick();
      drive(32'h00000193, 32'h0, 32'h0);
      tick();
      out_ready = 1'b0;
      drive(32'h00108133, 32'd1, 32'd1); #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_pre got ready=%b valid=%b exp 0/1", in_ready, out_valid); end
      #2; rst_n = 1'b0; #1;
      checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0) begin failures++; $display("FAIL async_reset got v=%b rd=%0d exp 0/0", out_valid, out_rd); end
      tick(); rst_n = 1'b1; out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_clears_busy got=%b exp=1", in_ready); end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_sub();
      test_shifts();
      test_lui_auipc_mem();
      test_hazard();
      test_backpressure_flush();
      test_illegal();
      test_reset_mid_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered instruction-decode stage that produces the operand and control bundle consumed by the core's ALU: x, y, funct3, funct7 and the imm flag.
- Accepts a fetched instruction and its PC over a valid/ready handshake.
- Reads the register file and builds immediates.
- A register scoreboard stalls issue on read-after-write hazards because the core has no forwarding. Writeback clears pending registers.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, register-address width (32 architectural registers).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- rf_raddr1  out  5  rs1 address, combinational from in_instr
- rf_raddr2  out  5  rs2 address, combinational from in_instr
- rf_rdata1  in  32  rs1 data, same-cycle asynchronous read
- rf_rdata2  in  32  rs2 data, same-cycle asynchronous read
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  5  register being written back
- flush  in  1  kill the held output entry
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes the bundle
- out_x  out  32  ALU operand x
- out_y  out  32  ALU operand y
- out_funct3  out  3  ALU operation select
- out_funct7  out  7  ALU funct7
- out_imm  out  1  ALU imm/arithmetic flag
- out_rd  out  5  destination register
- out_wen  out  1  writes rd (rd≠0)
- out_mem_rd  out  1  load
- out_mem_wr  out  1  store
- out_mem_funct3  out  3  load/store size/sign
- out_store_data  out  32  rs2 data for stores
- out_illegal  out  1  unsupported opcode

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, and every other out_* is 0.
  - Scoreboard is cleared (all busy bits 0).
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - On accept, the output register loads the decode result, out_valid=1, latency 1 cycle.
  - out_valid && !out_ready holds all out_* stable.
  - A transfer out with no accept clears out_valid.
- Hazard:
  - A source is a hazard when it is used, nonzero, and either its busy bit is set, or out_valid && out_wen && out_rd equals it.
  - hazard = the hazard term for rs1 OR the hazard term for rs2.
  - Busy bits are read from registered state; there is no same-cycle bypass.
- Scoreboard:
  - On out_valid && out_ready && out_wen, busy[out_rd] is set.
  - On wb_valid, busy[wb_rd] is cleared.
  - If a set and a clear hit the same register in one cycle, set wins.
  - x0 is never busy.
- Flush: clears out_valid next edge; out_* other than out_valid are don't-care. No busy bit is touched.
- Decode rules:
  - OP (0110011): x=rs1, y=rs2, funct3 and funct7 from instr, imm = (funct3==101) ? instr[30] : 0.
  - OP-IMM (0010011): x=rs1, y=sign-extended I-immediate (shifts: {27'b0, shamt}), funct3 from instr. funct7 = instr[31:25] when funct3 is 001/101, else 0. imm = (funct3==101) ? instr[30] : 1.
  - LUI: x=0, y={imm[31:12], 12'b0}, funct3=000, imm=1.
  - AUIPC: same as LUI but x=in_pc.
  - LOAD: x=rs1, y=I-immediate, funct3=000, imm=1, mem_rd=1, mem_funct3=instr[14:12].
  - STORE: x=rs1, y=S-immediate, funct3=000, imm=1, mem_wr=1, wen=0, store_data=rs2.
  - Any other opcode: illegal=1, wen=0, mem_rd=0, mem_wr=0, x=0, y=0. The bundle still issues.
- Source usage:
  - rs1 is used by OP, OP-IMM, LOAD and STORE.
  - rs2 is used by OP and STORE.
- out_wen = writes-rd opcode && rd≠0.

Optional Feature:
- Macro: DEC_WB_BYPASS_EN.
- Defined:
  - A source matching wb_rd while wb_valid is not a hazard in that cycle, provided it does not also match the held output entry.
  - The register file must be write-through in this configuration.
- Undefined: the stall is released one cycle after writeback.

Decomposition:
- Shared package rv_pkg:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE
  - funct3 constants F3_ADD … F3_AND
  - XLEN and REG_AW
  - a dec_bundle_t struct for the output register
- Sub-module rv_scoreboard:
  - contains the busy vector with its set/clear and query ports
  - the decode logic stays in rv_decode_stage

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 → next cycle: out_valid=1, x=0, y=0xFFFFFFFB, funct3=000, imm=1, rd=1, wen=1.
- SUB x3,x1,x2 with rf_rdata1=10 and rf_rdata2=3, scoreboard clear → funct3=000, funct7=0100000, imm=0, x=10, y=3.
- SRAI x4,x5,3 → y=3, funct3=101, funct7=0100000, imm=1. SRL x4,x5,x6 → imm=0.
- ADDI x1 issued, then ADD x2,x1,x1 → in_ready=0 until wb_valid with wb_rd=1. Without DEC_WB_BYPASS_EN, accept happens the cycle after writeback; with it, in the same cycle.
- Backpressure: out_ready=0 for 3 cycles → out_* stable and in_ready=0. Flush asserted while held → out_valid=0 next cycle, and the scoreboard bit for that rd stays 0.
- Opcode 1100011 (branch) → out_illegal=1, wen=0. Reset asserted mid-stall → out_valid=0 immediately and all busy bits clear.
